// File: rtl/video_stream_fifo_writer.sv
// Video stream to memory-master writer: frames pixels by SOP/EOP, tags each stored
// pixel with its frame index and buffers address/data pairs in a small FIFO.
module video_stream_fifo_writer #(
    parameter int unsigned DATA_W       = 16,
    parameter int unsigned FIFO_DEPTH   = 8,
    parameter int unsigned FRAME_PIXELS = 76800,
    parameter int unsigned ADDR_W       = 17
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [1:0]                    mode,
    input  logic [DATA_W-1:0]             fill_color,
    input  logic                          clear_error,
    input  logic [DATA_W-1:0]             stream_data,
    input  logic                          stream_startofpacket,
    input  logic                          stream_endofpacket,
    input  logic                          stream_valid,
    output logic                          stream_ready,
    input  logic                          master_waitrequest,
    output logic                          master_write,
    output logic [DATA_W-1:0]             master_writedata,
    output logic [ADDR_W-1:0]             master_address,
    output logic                          frame_done,
    output logic                          frame_error,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_PIXELS - 1);
    localparam logic [LVL_W-1:0]  FULL_LVL = LVL_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACTIVE  = 2'd1,
        DISCARD = 2'd2
    } state_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t            state, state_n;
    logic [ADDR_W-1:0] pix_cnt, pix_cnt_n;
    logic [1:0]        mode_q, mode_n, eff_mode;
    logic              done_q, done_n;
    logic              err_q, err_set;
    logic [LVL_W-1:0]  level;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    entry_t            mem [FIFO_DEPTH];
    entry_t            push_entry;
    logic              accept, push, pop;
    logic [ADDR_W-1:0] idx;
    logic              is_last;

    // Handshakes derive only from the registered level, so a full FIFO never accepts.
    assign stream_ready = ~reset & (level < FULL_LVL);
    assign accept       = stream_valid & stream_ready;
    assign master_write = ~reset & (level != '0);
    assign pop          = master_write & ~master_waitrequest;

    assign master_writedata = master_write ? mem[rd_ptr].data : '0;
    assign master_address   = master_write ? mem[rd_ptr].addr : '0;
    assign frame_done       = done_q & ~reset;
    assign frame_error      = err_q & ~reset;
    assign fifo_level       = reset ? '0 : level;

    // Framing FSM: an SOP beat always restarts the frame at index 0 with a fresh mode.
    always_comb begin
        state_n    = state;
        pix_cnt_n  = pix_cnt;
        mode_n     = mode_q;
        done_n     = 1'b0;
        err_set    = 1'b0;
        push       = 1'b0;
        idx        = stream_startofpacket ? '0 : pix_cnt;
        is_last    = (idx == LAST_IDX);
        eff_mode   = stream_startofpacket ? mode : mode_q;
        push_entry.addr = idx;
        case (eff_mode)
            2'd1:    push_entry.data = fill_color;
            2'd2:    push_entry.data = '0;
            default: push_entry.data = stream_data;
        endcase

        if (accept) begin
            if (stream_startofpacket) begin
                mode_n = mode;
                if (state == ACTIVE) begin
                    err_set = 1'b1;
                end
            end
            if (stream_startofpacket || state == ACTIVE) begin
                push      = 1'b1;
                pix_cnt_n = idx + ADDR_W'(1);
                if (stream_endofpacket) begin
                    state_n = IDLE;
                    if (is_last) begin
                        done_n = 1'b1;
                    end else begin
                        err_set = 1'b1;
                    end
                end else if (is_last) begin
                    state_n = DISCARD;
                    err_set = 1'b1;
                end else begin
                    state_n = ACTIVE;
                end
            end else if (state == DISCARD && stream_endofpacket) begin
                state_n = IDLE;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            pix_cnt <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            level   <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state   <= state_n;
            pix_cnt <= pix_cnt_n;
            mode_q  <= mode_n;
            done_q  <= done_n;
            // A new error in the same cycle as clear_error keeps the flag set.
            if (err_set) begin
                err_q <= 1'b1;
            end else if (clear_error) begin
                err_q <= 1'b0;
            end
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (!push && pop) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Storage needs no reset: entries are only visible while level is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_entry;
        end
    end

endmodule

// File: tb/tb_video_stream_fifo_writer.sv
// Scoreboard bench for video_stream_fifo_writer: a frame-level model predicts the
// write stream, frame_done and frame_error; a negedge monitor checks the DUT.
module tb_video_stream_fifo_writer;
    localparam int DW = 16;
    localparam int DEPTH = 4;
    localparam int FP = 4;
    localparam int AW = 8;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wr_t;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [1:0]    mode = 2'd0;
    logic [DW-1:0] fill_color = '0;
    logic          clear_error = 1'b0;
    logic [DW-1:0] stream_data = '0;
    logic          stream_startofpacket = 1'b0;
    logic          stream_endofpacket = 1'b0;
    logic          stream_valid = 1'b0;
    logic          stream_ready;
    logic          master_waitrequest = 1'b0;
    logic          master_write;
    logic [DW-1:0] master_writedata;
    logic [AW-1:0] master_address;
    logic          frame_done;
    logic          frame_error;
    logic [2:0]    fifo_level;

    video_stream_fifo_writer #(
        .DATA_W(DW), .FIFO_DEPTH(DEPTH), .FRAME_PIXELS(FP), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .mode(mode), .fill_color(fill_color),
        .clear_error(clear_error), .stream_data(stream_data),
        .stream_startofpacket(stream_startofpacket),
        .stream_endofpacket(stream_endofpacket), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .master_waitrequest(master_waitrequest),
        .master_write(master_write), .master_writedata(master_writedata),
        .master_address(master_address), .frame_done(frame_done),
        .frame_error(frame_error), .fifo_level(fifo_level)
    );

    always #5 clk = ~clk;

    int  vectors = 0;
    int  miscompares = 0;
    bit  mon_en = 1'b0;

    // Reference model state: a frame is "open" between SOP and its terminating pixel.
    wr_t      exp_q[$];
    bit       storing = 1'b0;
    int       idx = 0;
    logic [1:0] cur_mode = 2'd0;
    bit       err_model = 1'b0;
    bit       done_nx = 1'b0;
    bit       err_nx = 1'b0;
    bit       exp_done = 1'b0;
    bit       exp_err = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [DW-1:0] pix_of(input logic [1:0] md, input logic [DW-1:0] d,
                                             input logic [DW-1:0] f);
        if (md == 2'd1) return f;
        if (md == 2'd2) return '0;
        return d;
    endfunction

    task automatic model(input bit acc, input bit s, input bit e, input logic [DW-1:0] d,
                         input logic [1:0] m, input logic [DW-1:0] f, input bit clr);
        bit  store;
        wr_t w;
        store   = 1'b0;
        done_nx = 1'b0;
        if (clr) err_model = 1'b0;
        if (acc && s) begin
            if (storing) err_model = 1'b1;
            storing  = 1'b1;
            idx      = 0;
            cur_mode = m;
            store    = 1'b1;
        end else if (acc && storing) begin
            store = 1'b1;
        end
        if (store) begin
            w.addr = AW'(idx);
            w.data = pix_of(cur_mode, d, f);
            exp_q.push_back(w);
            if (e) begin
                storing = 1'b0;
                if (idx == FP - 1) done_nx = 1'b1;
                else err_model = 1'b1;
            end else if (idx == FP - 1) begin
                storing   = 1'b0;
                err_model = 1'b1;
            end
            idx++;
        end
        err_nx = err_model;
    endtask

    always @(posedge clk) begin
        exp_done <= done_nx;
        exp_err  <= err_nx;
    end

    // Monitor: per-cycle flag checks, write scoreboard, and head stability under stall.
    bit            held = 1'b0;
    logic [AW-1:0] hold_addr;
    logic [DW-1:0] hold_data;
    always @(negedge clk) begin
        wr_t e;
        if (mon_en) begin
            chk("frame_done", 32'(frame_done), reset ? 32'd0 : 32'(exp_done));
            chk("frame_error", 32'(frame_error), reset ? 32'd0 : 32'(exp_err));
            if (master_write) begin
                if (held) begin
                    chk("hold_addr", 32'(master_address), 32'(hold_addr));
                    chk("hold_data", 32'(master_writedata), 32'(hold_data));
                end
                if (!master_waitrequest) begin
                    vectors++;
                    if (exp_q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_write: got addr %0h data %0h expected none at %0t",
                                 master_address, master_writedata, $time);
                    end else begin
                        vectors--;
                        e = exp_q.pop_front();
                        chk("write_addr", 32'(master_address), 32'(e.addr));
                        chk("write_data", 32'(master_writedata), 32'(e.data));
                    end
                    held = 1'b0;
                end else begin
                    held      = 1'b1;
                    hold_addr = master_address;
                    hold_data = master_writedata;
                end
            end else begin
                held = 1'b0;
            end
        end
    end

    task automatic drive(input bit v, input bit s, input bit e, input logic [DW-1:0] d,
                         input logic [1:0] m, input logic [DW-1:0] f, input bit w,
                         input bit clr, output bit acc);
        @(posedge clk);
        #1;
        stream_valid         = v;
        stream_startofpacket = s;
        stream_endofpacket   = e;
        stream_data          = d;
        mode                 = m;
        fill_color           = f;
        master_waitrequest   = w;
        clear_error          = clr;
        acc = v && stream_ready;
        model(acc, s, e, d, m, f, clr);
    endtask

    task automatic beat(input bit s, input bit e, input logic [DW-1:0] d, input logic [1:0] m,
                        input logic [DW-1:0] f, input bit w);
        bit acc;
        int n;
        n = 0;
        do begin
            drive(1'b1, s, e, d, m, f, w, 1'b0, acc);
            n++;
        end while (!acc && n < 40);
        if (!acc) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_accept_timeout: got no accept expected accept at %0t", $time);
        end
    endtask

    task automatic idle(input int n, input bit w, input bit clr);
        bit acc;
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, '0, 2'd0, '0, w, clr, acc);
    endtask

    task automatic drain();
        bit acc;
        int n;
        n = 0;
        do begin
            drive(1'b0, 1'b0, 1'b0, '0, 2'd0, '0, 1'b0, 1'b0, acc);
            n++;
        end while ((exp_q.size() != 0 || master_write) && n < 60);
        idle(2, 1'b0, 1'b0);
        chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        stream_valid = 1'b0;
        stream_startofpacket = 1'b0;
        stream_endofpacket = 1'b0;
        master_waitrequest = 1'b0;
        clear_error = 1'b0;
        exp_q.delete();
        storing = 1'b0;
        idx = 0;
        cur_mode = 2'd0;
        err_model = 1'b0;
        done_nx = 1'b0;
        err_nx = 1'b0;
        #1;
        chk("rst_ready", 32'(stream_ready), 32'd0);
        chk("rst_write", 32'(master_write), 32'd0);
        chk("rst_level", 32'(fifo_level), 32'd0);
        chk("rst_done", 32'(frame_done), 32'd0);
        chk("rst_error", 32'(frame_error), 32'd0);
        chk("rst_wdata", 32'(master_writedata), 32'd0);
        chk("rst_addr", 32'(master_address), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        mon_en = 1'b1;
        #1;
        chk("post_rst_level", 32'(fifo_level), 32'd0);
        chk("post_rst_write", 32'(master_write), 32'd0);
        chk("post_rst_ready", 32'(stream_ready), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        do_reset();

        // Normal frame, mode 0
        beat(1, 0, 16'h0011, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0022, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0033, 2'd0, 16'h0, 0);
        beat(0, 1, 16'h0044, 2'd0, 16'h0, 0);
        drain();

        // Backpressure: stall long enough to fill the FIFO
        beat(1, 0, 16'h0101, 2'd0, 16'h0, 1);
        beat(0, 0, 16'h0102, 2'd0, 16'h0, 1);
        beat(0, 0, 16'h0103, 2'd0, 16'h0, 1);
        beat(0, 1, 16'h0104, 2'd0, 16'h0, 1);
        drive(1, 1, 0, 16'h0201, 2'd0, 16'h0, 1, 0, acc);
        chk("full_level", 32'(fifo_level), 32'd4);
        chk("full_ready", 32'(stream_ready), 32'd0);
        for (int i = 0; i < 5; i++) drive(1, 1, 0, 16'h0201, 2'd0, 16'h0, 1, 0, acc);
        beat(1, 0, 16'h0201, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0202, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0203, 2'd0, 16'h0, 0);
        beat(0, 1, 16'h0204, 2'd0, 16'h0, 0);
        drain();

        // Mode latched at SOP survives a mid-frame mode change
        beat(1, 0, 16'h1111, 2'd1, 16'hF800, 0);
        beat(0, 0, 16'h2222, 2'd0, 16'hF800, 0);
        beat(0, 0, 16'h3333, 2'd0, 16'hF800, 0);
        beat(0, 1, 16'h4444, 2'd0, 16'hF800, 0);
        drain();

        // Blank mode and a one-pixel frame
        beat(1, 0, 16'hABCD, 2'd2, 16'h1234, 0);
        beat(0, 0, 16'hABCE, 2'd3, 16'h1234, 0);
        beat(0, 0, 16'hABCF, 2'd1, 16'h1234, 0);
        beat(0, 1, 16'hABD0, 2'd0, 16'h1234, 0);
        beat(1, 1, 16'h5555, 2'd0, 16'h0, 0);
        drain();
        idle(1, 0, 1);

        // Short frame, then clear_error
        beat(1, 0, 16'h0A01, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0A02, 2'd0, 16'h0, 0);
        beat(0, 1, 16'h0A03, 2'd0, 16'h0, 0);
        drain();
        idle(1, 0, 1);
        idle(2, 0, 0);

        // Junk in IDLE, then an over-long frame
        beat(0, 0, 16'hDEAD, 2'd0, 16'h0, 0);
        beat(0, 1, 16'hBEEF, 2'd0, 16'h0, 0);
        for (int i = 0; i < 6; i++)
            beat(i == 0, i == 5, 16'(16'h0B01 + i), 2'd0, 16'h0, 0);
        drain();
        idle(1, 0, 1);

        // SOP cutting a frame short, with clear_error in the same cycle
        beat(1, 0, 16'h0C01, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0C02, 2'd0, 16'h0, 0);
        drive(1, 1, 0, 16'h0D01, 2'd0, 16'h0, 0, 1, acc);
        beat(0, 0, 16'h0D02, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0D03, 2'd0, 16'h0, 0);
        beat(0, 1, 16'h0D04, 2'd0, 16'h0, 0);
        drain();
        idle(1, 0, 1);

        // Reset mid-frame under stall, then a clean frame
        beat(1, 0, 16'h0E01, 2'd0, 16'h0, 1);
        beat(0, 0, 16'h0E02, 2'd0, 16'h0, 1);
        do_reset();
        beat(0, 0, 16'h0E03, 2'd0, 16'h0, 0);
        beat(1, 0, 16'h0F01, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0F02, 2'd0, 16'h0, 0);
        beat(0, 0, 16'h0F03, 2'd0, 16'h0, 0);
        beat(0, 1, 16'h0F04, 2'd0, 16'h0, 0);
        drain();

        // Randomised traffic with random stalls and clears
        for (int i = 0; i < 600; i++) begin
            drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, $urandom_range(0, 4) == 0,
                  16'($urandom), 2'($urandom), 16'($urandom), $urandom_range(0, 2) == 0,
                  $urandom_range(0, 15) == 0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/video_stream_fifo_writer.md
VIDEO_STREAM_FIFO_WRITER -- requirements
Module: video_stream_fifo_writer

Interface
REQ-001 Parameter DATA_W, default 16, pixel width in bits.
REQ-002 Parameter FIFO_DEPTH, default 8, output buffer entries; power of two, at least 2.
REQ-003 Parameter FRAME_PIXELS, default 76800, pixels per complete frame.
REQ-004 Parameter ADDR_W, default 17, pixel-index width; 2^ADDR_W must be at least FRAME_PIXELS.
REQ-005 clk  in  1  sole clock; all logic on the rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 mode  in  2  frame mode: 0 pass, 1 fill with fill_color, 2 blank (all zeros), 3 treated as 0.
REQ-008 fill_color  in  DATA_W  replacement pixel used in mode 1.
REQ-009 clear_error  in  1  clears frame_error.
REQ-010 stream_data  in  DATA_W  input pixel.
REQ-011 stream_startofpacket  in  1  first pixel of a frame.
REQ-012 stream_endofpacket  in  1  last pixel of a frame.
REQ-013 stream_valid  in  1  input beat valid.
REQ-014 stream_ready  out  1  block accepts the beat this cycle.
REQ-015 master_waitrequest  in  1  memory stall.
REQ-016 master_write  out  1  write request.
REQ-017 master_writedata  out  DATA_W  write pixel.
REQ-018 master_address  out  ADDR_W  pixel index of the write.
REQ-019 frame_done  out  1  one-cycle pulse on a correctly terminated frame.
REQ-020 frame_error  out  1  sticky framing error.
REQ-021 fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Function
REQ-022 A beat is accepted when stream_valid & stream_ready; stream_ready = ~reset & (level < FIFO_DEPTH), combinational from the registered level; there is no pass-through while full, even if a pop occurs in the same cycle.
REQ-023 The FSM has three states: IDLE (wait for SOP), ACTIVE (store pixels), DISCARD (drop until EOP or SOP).
REQ-024 In IDLE, accepted beats without SOP are discarded and not pushed.
REQ-025 An accepted SOP beat in any state does all of: push at address 0, latch mode for the whole frame, set the pixel counter to 1, and enter ACTIVE (or stay ACTIVE).
REQ-026 An accepted SOP beat while in ACTIVE also sets frame_error, because the previous frame was short.
REQ-027 In ACTIVE, each accepted non-SOP beat is pushed with address = pixel counter, and the counter then increments.
REQ-028 An accepted EOP in ACTIVE whose pixel index equals FRAME_PIXELS-1 pushes the beat, pulses frame_done in the next cycle, and enters IDLE.
REQ-029 An accepted EOP in ACTIVE with any other index pushes the beat, sets frame_error, enters IDLE, and gives no frame_done.
REQ-030 An accepted non-EOP beat at index FRAME_PIXELS-1 is pushed, then the FSM enters DISCARD and sets frame_error.
REQ-031 DISCARD drops all beats; EOP returns to IDLE, and SOP follows REQ-025.
REQ-032 A beat carrying both SOP and EOP is a one-pixel frame; it is pushed and follows REQ-028 or REQ-029 with index 0.
REQ-033 Pushed data is stream_data in mode 0, fill_color in mode 1, and 0 in mode 2, using the latched mode.
REQ-034 master_write = (level != 0); master_writedata and master_address present the FIFO head.
REQ-035 A pop occurs when master_write & ~master_waitrequest; head outputs must hold stable while master_waitrequest is high.
REQ-036 Simultaneous push and pop leaves level unchanged; FIFO pointers wrap modulo FIFO_DEPTH.
REQ-037 Minimum latency is one cycle: a beat accepted in cycle N appears on master_write in cycle N+1.
REQ-038 frame_error sets on REQ-026, REQ-029 and REQ-030, and clears only on clear_error or reset.
REQ-039 When clear_error is high in the same cycle as a new error, the error set wins.

Reset
REQ-040 While reset is high: stream_ready=0, master_write=0, fifo_level=0, frame_done=0, frame_error=0, FSM in IDLE, pixel counter 0, latched mode 0, master_writedata and master_address 0.
REQ-041 Reset asserted mid-frame discards all FIFO contents and the partial frame.
REQ-042 After reset, no write occurs until a new SOP is accepted.

Verification (FRAME_PIXELS=4, FIFO_DEPTH=4, DATA_W=16)
REQ-043 Normal frame: pixels 0x0011..0x0044 with SOP on the first and EOP on the fourth, mode 0, waitrequest low -> writes (0,0x0011)..(3,0x0044); one frame_done pulse; frame_error stays 0.
REQ-044 Backpressure: waitrequest held high for 10 cycles during the frame -> stream_ready falls after 4 accepts with fifo_level=4; on release, in-order writes with no loss or duplication.
REQ-045 Mode latch: mode=1 with fill_color=0xF800 at SOP, then mode changed to 0 mid-frame -> all 4 writes carry 0xF800.
REQ-046 Short frame: EOP on the third pixel -> 3 writes, frame_error=1, no frame_done; clear_error then drops frame_error to 0.
REQ-047 Long frame plus junk: 6 pixels with EOP on the sixth, preceded by 2 non-SOP beats in IDLE -> IDLE beats dropped, addresses 0..3 written, pixels 5-6 dropped, frame_error=1.
REQ-048 Reset mid-frame: reset after 2 accepts with waitrequest high -> fifo_level=0, master_write=0; a following good frame writes addresses 0..3.
